// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - LSU-side memory controller routing byte accesses to SRAM or IO bus
//
// Purpose: accepts a level-held LSU read/write request, decodes the address to
// the synchronous data SRAM (addr < IO_BASE) or to the memory-mapped IO bus
// (addr >= IO_BASE), runs the access and returns a one-cycle rdy pulse.
//
// Optional build macro: MEM_IO_TIMEOUT_EN
//   defined   - IO accesses abort after IO_TIMEOUT cycles without io_ack,
//               returning rdata = 8'hFF on reads and pulsing bus_err with rdy.
//   undefined - IO accesses wait indefinitely; bus_err is tied 0.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   addr, wdata, read, write         LSU request (level, held until rdy)
//   rdata, rdy                       registered read data, completion pulse
//   ram_ce/we/addr/wdata, ram_rdata  synchronous SRAM interface
//   io_req/we/addr/wdata, io_rdata,
//   io_ack                           IO bus handshake
//   bus_err                          IO timeout flag, pulses with rdy

module lsu_mem_ctrl #(
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int          RAM_WAIT   = 1,
    parameter int          IO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        read,
    input  logic        write,
    output logic [7:0]  rdata,
    output logic        rdy,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic        io_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_RAM_ACC, S_IO_ACC, S_DONE} state_t;

    localparam logic [3:0] LP_RAM_WAIT = 4'(RAM_WAIT);

    state_t     r_state;
    logic       r_dir;      // 1 = write; write wins when both requests are high
    logic [3:0] r_wait;
    logic       w_req;

    assign w_req = read | write;

`ifdef MEM_IO_TIMEOUT_EN
    // Loaded with IO_TIMEOUT-1 so io_req stays high for exactly IO_TIMEOUT cycles.
    localparam logic [7:0] LP_TMO_LOAD = 8'(IO_TIMEOUT - 1);
    logic [7:0] r_tmo;
    logic       r_err;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_wait    <= 4'd0;
            rdata     <= 8'h00;
            rdy       <= 1'b0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 16'h0000;
            ram_wdata <= 8'h00;
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= 8'h00;
            io_wdata  <= 8'h00;
`ifdef MEM_IO_TIMEOUT_EN
            r_tmo     <= 8'd0;
            r_err     <= 1'b0;
            bus_err   <= 1'b0;
`endif
        end else begin
            rdy <= 1'b0;
`ifdef MEM_IO_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_dir <= write;
                        if (addr < IO_BASE) begin
                            r_state   <= S_RAM_ACC;
                            ram_ce    <= 1'b1;
                            ram_we    <= write;
                            ram_addr  <= addr;
                            ram_wdata <= wdata;
                            r_wait    <= LP_RAM_WAIT;
                        end else begin
                            r_state  <= S_IO_ACC;
                            io_req   <= 1'b1;
                            io_we    <= write;
                            io_addr  <= addr[7:0];
                            io_wdata <= wdata;
`ifdef MEM_IO_TIMEOUT_EN
                            r_tmo    <= LP_TMO_LOAD;
`endif
                        end
                    end
                end

                S_RAM_ACC: begin
                    // SRAM data is valid on the last ce cycle; sample it as ce drops.
                    if (r_wait == 4'd0) begin
                        if (!r_dir) begin
                            rdata <= ram_rdata;
                        end
                        ram_ce  <= 1'b0;
                        ram_we  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end

                S_IO_ACC: begin
                    // io_ack is checked first so an ack on the timeout cycle wins.
                    if (io_ack) begin
                        if (!r_dir) begin
                            rdata <= io_rdata;
                        end
                        io_req  <= 1'b0;
                        io_we   <= 1'b0;
                        r_state <= S_DONE;
                    end
`ifdef MEM_IO_TIMEOUT_EN
                    else if (r_tmo == 8'd0) begin
                        if (!r_dir) begin
                            rdata <= 8'hFF;
                        end
                        io_req  <= 1'b0;
                        io_we   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo - 8'd1;
                    end
`endif
                end

                S_DONE: begin
                    rdy     <= 1'b1;
`ifdef MEM_IO_TIMEOUT_EN
                    bus_err <= r_err;
                    r_err   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

    localparam int RAM_WAIT   = 1;
    localparam int IO_TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        read;
    logic        write;
    logic [7:0]  rdata;
    logic        rdy;
    logic        ram_ce;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        io_req;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        io_ack;
    logic        bus_err;

    int n_total = 0;
    int n_pass  = 0;

    lsu_mem_ctrl #(
        .IO_BASE   (16'hFF00),
        .RAM_WAIT  (RAM_WAIT),
        .IO_TIMEOUT(IO_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wdata    (wdata),
        .read     (read),
        .write    (write),
        .rdata    (rdata),
        .rdy      (rdy),
        .ram_ce   (ram_ce),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .io_req   (io_req),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .io_ack   (io_ack),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  wd;
        logic        rd;
        logic        wr;
        logic [7:0]  rr;
        logic        exp_we;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[5];

    // One SRAM transaction; the LSU's addr/wdata are scrambled after the first
    // edge to show the latched copies are used.
    task automatic ram_txn(input int idx, input vec_t v);
        int   ce_n   = 0;
        int   rdy_k  = 0;
        int   io_n   = 0;
        logic bus_ok = 1'b1;
        addr = v.a; wdata = v.wd; read = v.rd; write = v.wr; ram_rdata = v.rr;
        for (int k = 1; k <= 20 && rdy_k == 0; k++) begin
            tick();
            if (k == 1) begin
                addr  = v.a ^ 16'h00F0;
                wdata = ~v.wd;
            end
            if (ram_ce) begin
                ce_n++;
                if (ram_we !== v.exp_we || ram_addr !== v.a || (v.exp_we && ram_wdata !== v.wd))
                    bus_ok = 1'b0;
            end
            if (io_req) io_n++;
            if (rdy) begin
                rdy_k = k;
                read  = 1'b0;
                write = 1'b0;
            end
        end
        chk($sformatf("v%0d ram_ce cycles", idx), ce_n, RAM_WAIT + 1);
        chk($sformatf("v%0d rdy latency", idx), rdy_k, RAM_WAIT + 3);
        chk($sformatf("v%0d ram bus fields", idx), bus_ok, 1);
        chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d io untouched", idx), io_n, 0);
        tick();
        chk($sformatf("v%0d no extra rdy", idx), rdy, 0);
    endtask

    // One IO transaction with io_ack raised after observing cycle adel.
    task automatic io_txn(input string nm, input logic [15:0] a, input logic rd, input logic wr,
                          input logic [7:0] wd, input int adel, input logic [7:0] ird,
                          input logic [7:0] exp_rdata);
        int   req_n  = 0;
        int   rdy_k  = 0;
        int   ram_n  = 0;
        logic bus_ok = 1'b1;
        addr = a; wdata = wd; read = rd; write = wr;
        for (int k = 1; k <= 40 && rdy_k == 0; k++) begin
            tick();
            if (k == 1) begin
                addr  = 16'h0000;
                wdata = 8'h00;
            end
            io_ack   = 1'b0;
            io_rdata = 8'h00;
            if (io_req) begin
                req_n++;
                if (io_addr !== a[7:0] || io_we !== wr || (wr && io_wdata !== wd)) bus_ok = 1'b0;
            end
            if (ram_ce) ram_n++;
            if (k == adel) begin
                io_ack   = 1'b1;
                io_rdata = ird;
            end
            if (rdy) begin
                rdy_k = k;
                read  = 1'b0;
                write = 1'b0;
            end
        end
        chk({nm, " io_req cycles"}, req_n, adel);
        chk({nm, " rdy latency"}, rdy_k, adel + 2);
        chk({nm, " io bus fields"}, bus_ok, 1);
        chk({nm, " rdata"}, rdata, exp_rdata);
        chk({nm, " bus_err"}, bus_err, 0);
        chk({nm, " ram untouched"}, ram_n, 0);
    endtask

    initial begin
        int rdy_cnt;
        int first_k;
        int second_k;
        int req_n;
        int rdy_k;
        int err_n;

        vecs[0] = '{16'h1234, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[1] = '{16'h1234, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5};
        vecs[2] = '{16'h0040, 8'h11, 1'b1, 1'b1, 8'h77, 1'b1, 8'hA5};
        vecs[3] = '{16'hFEFF, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h5A};
        vecs[4] = '{16'h0000, 8'hC3, 1'b0, 1'b1, 8'h99, 1'b1, 8'h5A};

        rst_n = 1'b0; addr = 16'h0000; wdata = 8'h00; read = 1'b0; write = 1'b0;
        ram_rdata = 8'h00; io_rdata = 8'h00; io_ack = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset ctrl outputs", {rdy, ram_ce, ram_we, io_req, io_we, bus_err}, 0);
        rst_n = 1'b1;
        tick();
        chk("post-reset ctrl outputs", {rdy, ram_ce, ram_we, io_req, io_we, bus_err}, 0);
        chk("post-reset rdata", rdata, 8'h00);
        chk("post-reset buses", {ram_addr, ram_wdata, io_addr, io_wdata}, 0);

        // Reset in the middle of an SRAM access
        read = 1'b1; addr = 16'h0100; ram_rdata = 8'h66;
        tick();
        chk("mid-reset ram_ce before", ram_ce, 1);
        rst_n = 1'b0;
        #1;
        chk("mid-reset ram_ce async drop", ram_ce, 0);
        read = 1'b0;
        tick();
        rst_n = 1'b1;
        rdy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rdy) rdy_cnt++;
        end
        chk("mid-reset no rdy", rdy_cnt, 0);
        chk("mid-reset rdata", rdata, 8'h00);

        // Table-driven SRAM vectors
        for (int i = 0; i < 5; i++) ram_txn(i, vecs[i]);

        // Back-to-back reads with read held across rdy
        read = 1'b1; write = 1'b0; addr = 16'h0000; ram_rdata = 8'h12;
        rdy_cnt = 0; first_k = 0; second_k = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (rdy) begin
                rdy_cnt++;
                if (rdy_cnt == 1) begin
                    first_k = k;
                    chk("b2b first rdata", rdata, 8'h12);
                    addr = 16'h0001; ram_rdata = 8'h34;
                end else if (rdy_cnt == 2) begin
                    second_k = k;
                    chk("b2b second rdata", rdata, 8'h34);
                    chk("b2b second ram_addr", ram_addr, 16'h0001);
                    read = 1'b0;
                end
            end
        end
        chk("b2b rdy count", rdy_cnt, 2);
        chk("b2b spacing", second_k - first_k, RAM_WAIT + 3);

        // IO decode
        io_txn("io rd ff10", 16'hFF10, 1'b1, 1'b0, 8'h00, 4, 8'h3C, 8'h3C);
        io_txn("io wr ffff", 16'hFFFF, 1'b0, 1'b1, 8'hE7, 1, 8'h99, 8'h3C);
        io_txn("io rd ff00", 16'hFF00, 1'b1, 1'b0, 8'h00, 2, 8'hC1, 8'hC1);

        // Stray io_ack while idle
        io_ack = 1'b1; io_rdata = 8'hAA;
        rdy_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rdy || io_req) rdy_cnt++;
        end
        io_ack = 1'b0; io_rdata = 8'h00;
        chk("stray ack ignored", rdy_cnt, 0);
        chk("stray ack rdata", rdata, 8'hC1);

        // IO read with no acknowledge
        read = 1'b1; addr = 16'hFF00;
        req_n = 0; rdy_k = 0; err_n = 0;
        for (int k = 1; k <= 40 && rdy_k == 0; k++) begin
            tick();
            if (io_req) req_n++;
            if (bus_err) err_n++;
            if (rdy) begin
                rdy_k = k;
                chk("timeout bus_err with rdy", bus_err, 1'b1 `ifndef MEM_IO_TIMEOUT_EN & 1'b0 `endif);
                read = 1'b0;
            end
        end
`ifdef MEM_IO_TIMEOUT_EN
        chk("timeout io_req cycles", req_n, IO_TIMEOUT);
        chk("timeout rdy latency", rdy_k, IO_TIMEOUT + 2);
        chk("timeout bus_err count", err_n, 1);
        chk("timeout rdata", rdata, 8'hFF);
        tick();
        chk("timeout bus_err drops", {bus_err, rdy}, 0);

        // Acknowledge on the timeout cycle wins over the abort
        io_txn("ack at timeout", 16'hFF20, 1'b1, 1'b0, 8'h00, IO_TIMEOUT, 8'h5C, 8'h5C);
`else
        chk("no-timeout io_req held", req_n, 40);
        chk("no-timeout rdy", rdy_k, 0);
        chk("no-timeout bus_err", err_n, 0);
        chk("no-timeout io_req still", io_req, 1);
        read = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset drops io_req async", io_req, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("after reset rdata", rdata, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Memory-side controller directly downstream of the LSU. It accepts the LSU's level-held byte request (addr, wdata, read, write) and routes it to the synchronous data SRAM or to the memory-mapped IO bus, depending on the address. It returns the read byte on rdata and signals completion with a one-cycle rdy pulse, which the LSU forwards as mem_ok.

Parameters:
IO_BASE, 16'hFF00, first address decoded to the IO bus; addresses below it go to SRAM
RAM_WAIT, 1, extra SRAM wait cycles (0..15)
IO_TIMEOUT, 16, IO cycles allowed without io_ack before abort (timeout build only, 2..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
addr  in  16  LSU byte address
wdata  in  8  LSU write data
read  in  1  LSU read request, level, held until rdy
write  in  1  LSU write request, level, held until rdy
rdata  out  8  read data, registered
rdy  out  1  one-cycle completion pulse
ram_ce  out  1  SRAM chip enable
ram_we  out  1  SRAM write enable
ram_addr  out  16  SRAM address
ram_wdata  out  8  SRAM write data
ram_rdata  in  8  SRAM read data, valid one cycle after ce with address
io_req  out  1  IO request, held until io_ack
io_we  out  1  IO write
io_addr  out  8  IO register offset, addr[7:0]
io_wdata  out  8  IO write data
io_rdata  in  8  IO read data, sampled with io_ack
io_ack  in  1  IO completion
bus_err  out  1  one-cycle pulse with rdy on IO timeout

Behaviour:
- Clocking: single clock. Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: every output is 0, including rdata = 8'h00. The FSM is in IDLE.
- FSM states: IDLE, RAM_ACC, IO_ACC, DONE.
- IDLE: samples read|write on each clock.
  - On a request, latch addr, wdata and dir (write has priority if both read and write are high).
  - Go to RAM_ACC if addr < IO_BASE, otherwise go to IO_ACC.
- RAM_ACC:
  - ram_ce = 1 for exactly RAM_WAIT+1 cycles. ram_addr, ram_we = dir and ram_wdata are stable for that whole interval.
  - Wait counter loads RAM_WAIT on entry and decrements each cycle.
  - On the cycle the counter reads 0, a read captures ram_rdata into rdata. Then go to DONE.
- IO_ACC:
  - io_req = 1, with io_we, io_addr and io_wdata stable.
  - io_ack is accepted on any IO_ACC cycle, including the first.
  - On io_ack, a read captures io_rdata into rdata, io_req drops on the next edge, and the FSM goes to DONE.
  - io_ack seen outside IO_ACC is ignored.
- DONE: rdy = 1 for exactly one cycle, then return to IDLE. Requests present during DONE are ignored. A request held in the following cycle is treated as a new transaction, so back-to-back accesses are allowed.
- Latency (request first seen high at edge N):
  - SRAM: rdy high in cycle N+RAM_WAIT+2.
  - IO: rdy two cycles after the io_ack cycle.
- rdata holds the last read value. Writes never change rdata.
- A change on the LSU's addr/wdata mid-transaction is ignored; the latched copies are used.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and io_req/ram_ce drop asynchronously. The partial access is lost and no rdy is issued.
- Boundary addresses: 16'hFEFF goes to SRAM; 16'hFF00 and 16'hFFFF go to IO.

Optional Feature:
MEM_IO_TIMEOUT_EN
- Defined: a counter runs during IO_ACC. After IO_TIMEOUT cycles without io_ack:
  - io_req drops;
  - a read sets rdata = 8'hFF;
  - the FSM goes to DONE with bus_err = 1 for the same single cycle as rdy.
  - io_ack arriving on the same cycle as the timeout wins, and no error is raised.
- Undefined: IO_ACC waits indefinitely for io_ack. The bus_err port remains but is tied 0.

Test Plan:
1. Reset: hold rst_n = 0, then release -> all outputs 0 and rdata = 8'h00. Assert rst_n = 0 mid RAM_ACC -> ram_ce drops immediately and no rdy follows.
2. RAM write then read, RAM_WAIT = 1: write addr 16'h1234, wdata 8'hA5 -> ram_ce/ram_we high 2 cycles and rdy at N+3. Then read 16'h1234 with ram_rdata = 8'hA5 -> rdata = 8'hA5 with rdy at N+3, ram_we = 0.
3. Back-to-back: hold read across rdy at 16'h0000 then 16'h0001 -> two rdy pulses spaced RAM_WAIT+3 cycles apart, with no extra transaction.
4. IO decode: read 16'hFF10, io_ack after 4 cycles with io_rdata = 8'h3C -> io_addr = 8'h10, rdata = 8'h3C, rdy pulses. Address 16'hFEFF must hit SRAM, not IO.
5. Simultaneous read & write at 16'h0040, wdata 8'h11 -> a single write (ram_we = 1) and rdata unchanged.
6. With MEM_IO_TIMEOUT_EN and IO_TIMEOUT = 16: read 16'hFF00, never ack -> io_req drops after 16 cycles, rdata = 8'hFF, rdy and bus_err high for one cycle together. Without the macro, the same stimulus leaves io_req held, rdy never rises, and bus_err stays 0.
